fetch_unit: RTL

Instruction fetch front end for the 64-bit single-cycle core. It consumes the next-PC stream from the program counter and branch unit, issues in-order read requests to instruction memory, and buffers the returned instructions with their PCs in a small FIFO. It presents them to decode over a valid/ready handshake and flushes all in-flight work when a taken branch redirects the PC.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and the FIFO entry layout for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES   = 4;
    localparam int unsigned FETCH_ADDR_W  = 64;
    localparam int unsigned FETCH_INSTR_W = 32;

    localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = 64'h0;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with clear; clear wins over push and pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned DATA_W = FETCH_ADDR_W + FETCH_INSTR_W,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Storage is not reset; the head is only meaningful while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited in-order requests, response FIFO, redirect flush.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter  int unsigned       ADDR_W   = FETCH_ADDR_W,
    parameter  int unsigned       INSTR_W  = FETCH_INSTR_W,
    parameter  int unsigned       DEPTH    = 4,
    parameter  logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    localparam int unsigned       CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    input  logic               dec_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic [ADDR_W+INSTR_W-1:0] fifo_head;
    logic                      req_fire;
    logic                      rsp_keep;

    // Handshakes: a transfer happens in a cycle where valid and ready are both high;
    // valid may drop without a transfer and carries no stability promise.
    // Credit counts buffered plus in-flight words so the FIFO can never overflow.
    assign imem_req_valid = rst && (({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep  = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
    assign fifo_push = rsp_keep && !fifo_full;

    assign dec_valid          = !fifo_empty && !redirect_valid;
    assign fifo_pop           = dec_valid && dec_ready;
    assign {dec_pc, dec_instr} = fifo_empty ? '0 : fifo_head;

    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
            end
            if (imem_rsp_valid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - 1'b1;
                end else begin
                    rsp_pc_d = rsp_pc_q + ADDR_W'(INSTR_BYTES);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ADDR_W + INSTR_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (redirect_valid),
        .push_i      (fifo_push),
        .pop_i       (fifo_pop),
        .push_data_i ({rsp_pc_q, imem_rsp_data}),
        .head_data_o (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (dec_ready && !dec_valid && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
            if (redirect_valid && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + 1'b1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
